// File: rtl/apb2mem_pkg.sv
// Shared types and widths for the APB4-to-native-memory bridge.
// The optional timeout watchdog is enabled by defining APB2MEM_TIMEOUT_EN.
package apb2mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned WDT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Native request captured from the APB setup phase and held through REQ.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/apb2mem_wdt.sv
// Request watchdog: cleared on load, counts ticks, flags the tick that reaches LIMIT.
module apb2mem_wdt
    import apb2mem_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    output logic expire_c
);

    logic [WDT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= cnt_q + WDT_W'(1);
        end
    end

    // Fires on the LIMIT-th waiting cycle so the request is dropped right after it.
    assign expire_c = tick && (cnt_q == WDT_W'(LIMIT - 1));

endmodule

// File: rtl/apb2mem.sv
// APB4 completer that replays each transfer as one valid/ready native memory request.
// Define APB2MEM_TIMEOUT_EN to add a watchdog that completes stuck requests with PSLVERR.
module apb2mem
    import apb2mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_OFFSET = 32'h0000_0000
`ifdef APB2MEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] apb_paddr_i,
    input  logic [2:0]        apb_pprot_i,
    input  logic              apb_psel_i,
    input  logic              apb_penable_i,
    input  logic              apb_pwrite_i,
    input  logic [DATA_W-1:0] apb_pwdata_i,
    input  logic [STRB_W-1:0] apb_pstrb_i,
    output logic              apb_pready_o,
    output logic [DATA_W-1:0] apb_prdata_o,
    output logic              apb_pslverr_o,
    output logic              mem_valid_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [STRB_W-1:0] mem_wstrb_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i
);

    state_t            state_q, state_d;
    mem_req_t          req_q, req_d;
    logic              valid_q, valid_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              wdt_expire;
    logic              unused_pprot;

    assign unused_pprot = ^apb_pprot_i;

`ifdef APB2MEM_TIMEOUT_EN
    logic wdt_load;
    logic wdt_tick;

    assign wdt_load = (state_q == ST_IDLE) && (state_d == ST_REQ);
    assign wdt_tick = (state_q == ST_REQ) && !mem_ready_i;

    apb2mem_wdt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .load     (wdt_load),
        .tick     (wdt_tick),
        .expire_c (wdt_expire)
    );
`else
    assign wdt_expire = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            valid_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Next state plus next values of the registered outputs (response fields are zero outside RESP).
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        valid_d   = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (apb_psel_i && !apb_penable_i) begin
                    req_d.write = apb_pwrite_i;
                    req_d.addr  = {apb_paddr_i[ADDR_W-1:2], 2'b00} + ADDR_OFFSET;
                    req_d.wdata = apb_pwdata_i;
                    req_d.wstrb = apb_pwrite_i ? apb_pstrb_i : '0;
                    if (apb_paddr_i[1:0] != 2'b00) begin
                        state_d   = ST_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else if (apb_pwrite_i && (apb_pstrb_i == '0)) begin
                        state_d  = ST_RESP;
                        pready_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        valid_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ready_i) begin
                    state_d  = ST_RESP;
                    pready_d = 1'b1;
                    prdata_d = req_q.write ? '0 : mem_rdata_i;
                end else if (wdt_expire) begin
                    state_d   = ST_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign apb_pready_o  = pready_q;
    assign apb_prdata_o  = prdata_q;
    assign apb_pslverr_o = pslverr_q;
    assign mem_valid_o   = valid_q;
    assign mem_addr_o    = req_q.addr;
    assign mem_wdata_o   = req_q.wdata;
    assign mem_wstrb_o   = req_q.wstrb;

endmodule

// File: tb/tb_apb2mem.sv
// Self-checking bench for apb2mem: vector table of APB transfers with a native memory responder.
// Timeout vectors are included when APB2MEM_TIMEOUT_EN is defined.
module tb_apb2mem;

    localparam logic [31:0] OFFSET = 32'h2000_0000;
`ifdef APB2MEM_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`endif
    localparam int NEVER = 255;

    logic        clk;
    logic        rst_n;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        int          delay;
        int          gap;
        logic [31:0] e_prdata;
        bit          e_err;
        int          e_waits;
        int          e_vcyc;
        logic [31:0] e_maddr;
        logic [3:0]  e_wstrb;
    } vec_t;

    typedef struct {
        logic [31:0] prdata;
        bit          err;
        int          waits;
    } resp_t;

    vec_t  vecs[$];
    resp_t sb[$];

    apb2mem #(
        .ADDR_OFFSET(OFFSET)
`ifdef APB2MEM_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .apb_paddr_i   (paddr),
        .apb_pprot_i   (pprot),
        .apb_psel_i    (psel),
        .apb_penable_i (penable),
        .apb_pwrite_i  (pwrite),
        .apb_pwdata_i  (pwdata),
        .apb_pstrb_i   (pstrb),
        .apb_pready_o  (pready),
        .apb_prdata_o  (prdata),
        .apb_pslverr_o (pslverr),
        .mem_valid_o   (mem_valid),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_wstrb_o   (mem_wstrb),
        .mem_rdata_i   (mem_rdata),
        .mem_ready_i   (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: derives every expected response from the stimulus alone.
    function automatic vec_t make_vec(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [3:0] strb, input logic [31:0] rdata,
                                      input int delay, input int gap);
        vec_t v;
        bit native;
        bit tmo;
        v.write = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.rdata = rdata; v.delay = delay; v.gap = gap;
        native = (addr[1:0] == 2'b00) && !(wr && (strb == 4'h0));
        tmo = 1'b0;
`ifdef APB2MEM_TIMEOUT_EN
        tmo = native && (delay >= int'(TMO));
`endif
        v.e_err    = (addr[1:0] != 2'b00) || tmo;
        v.e_prdata = (wr || v.e_err) ? 32'h0 : rdata;
        v.e_maddr  = {addr[31:2], 2'b00} + OFFSET;
        v.e_wstrb  = wr ? strb : 4'h0;
        if (!native) begin
            v.e_waits = 1;
            v.e_vcyc  = 0;
        end else if (tmo) begin
`ifdef APB2MEM_TIMEOUT_EN
            v.e_waits = int'(TMO) + 1;
            v.e_vcyc  = int'(TMO);
`endif
        end else begin
            v.e_waits = delay + 2;
            v.e_vcyc  = delay + 1;
        end
        return v;
    endfunction

    task automatic idle_cycle();
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    endtask

    // One APB transfer starting next cycle; the memory side answers after v.delay REQ cycles.
    task automatic run_xfer(input vec_t v, input string tag);
        int    c;
        int    vcnt;
        bit    done;
        resp_t r;
        resp_t e;
        @(posedge clk); #1;
        chk({tag, "_pre_pready"}, 32'(pready), 32'h0);
        chk({tag, "_pre_valid"}, 32'(mem_valid), 32'h0);
        psel = 1'b1; penable = 1'b0; paddr = v.addr; pwrite = v.write;
        pwdata = v.wdata; pstrb = v.strb; mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        r.prdata = v.e_prdata; r.err = v.e_err; r.waits = v.e_waits;
        sb.push_back(r);
        c = 0; vcnt = 0; done = 1'b0;
        while (!done && c < 60) begin
            @(posedge clk); #1;
            c++;
            penable = 1'b1; mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
            if (mem_valid) begin
                if (vcnt == 0) begin
                    chk({tag, "_mem_addr"}, mem_addr, v.e_maddr);
                    chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'(v.e_wstrb));
                    if (v.write) chk({tag, "_mem_wdata"}, mem_wdata, v.wdata);
                end
                if (vcnt == v.delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = v.rdata;
                end
                vcnt++;
            end
            if (pready) begin
                done = 1'b1;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL %s_sb_empty: pready with no expected response", tag);
                end else begin
                    e = sb.pop_front();
                    chk({tag, "_pready_cycle"}, 32'(c), 32'(e.waits));
                    chk({tag, "_prdata"}, prdata, e.prdata);
                    chk({tag, "_pslverr"}, 32'(pslverr), 32'(e.err));
                    chk({tag, "_valid_in_resp"}, 32'(mem_valid), 32'h0);
                end
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_no_pready: got none within %0d cycles expected cycle %0d", tag, c, v.e_waits);
            void'(sb.pop_front());
        end
        chk({tag, "_valid_cycles"}, 32'(vcnt), 32'(v.e_vcyc));
    endtask

    initial begin
        vec_t fresh;
        rst_n = 1'b0; paddr = '0; pprot = 3'b000; psel = 1'b0; penable = 1'b0;
        pwrite = 1'b0; pwdata = '0; pstrb = '0; mem_rdata = '0; mem_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pready", 32'(pready), 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_pslverr", 32'(pslverr), 32'h0);
        chk("rst_valid", 32'(mem_valid), 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'h0);
        rst_n = 1'b1;
        idle_cycle();

        //                   wr    addr           wdata          strb     rdata          delay gap
        vecs.push_back(make_vec(1'b0, 32'h0000_0100, 32'h0,         4'h0,    32'hDEAD_BEEF, 0,    0));
        vecs.push_back(make_vec(1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011, 32'hCAFE_0001, 4,    1));
        vecs.push_back(make_vec(1'b0, 32'h0000_0102, 32'h0,         4'h0,    32'h1111_1111, 0,    0));
        vecs.push_back(make_vec(1'b1, 32'h0000_0200, 32'h5555_AAAA, 4'h0,    32'h2222_2222, 0,    2));
        vecs.push_back(make_vec(1'b1, 32'h0000_0203, 32'h7777_8888, 4'hF,    32'h3333_3333, 0,    0));
        vecs.push_back(make_vec(1'b0, 32'hF000_0004, 32'h0,         4'hF,    32'hA5A5_5A5A, 2,    1));
        vecs.push_back(make_vec(1'b0, 32'h0000_0040, 32'h0,         4'h0,    32'h0123_4567, 0,    0));
        vecs.push_back(make_vec(1'b0, 32'h0000_0044, 32'h0,         4'h0,    32'h89AB_CDEF, 1,    0));
        vecs.push_back(make_vec(1'b1, 32'h0000_0ABC, 32'hFEED_FACE, 4'b1100, 32'h4444_4444, 0,    0));
        vecs.push_back(make_vec(1'b0, 32'h0000_0800, 32'h0,         4'h0,    32'h5A5A_0F0F, 10,   1));
`ifdef APB2MEM_TIMEOUT_EN
        vecs.push_back(make_vec(1'b0, 32'h0000_0900, 32'h0,         4'h0,    32'h6666_6666, NEVER, 1));
        vecs.push_back(make_vec(1'b0, 32'h0000_0904, 32'h0,         4'h0,    32'h0BAD_F00D, 3,    0));
        vecs.push_back(make_vec(1'b1, 32'h0000_0908, 32'h1357_9BDF, 4'hF,    32'h7777_7777, NEVER, 0));
`endif

        foreach (vecs[i]) begin
            repeat (vecs[i].gap) idle_cycle();
            run_xfer(vecs[i], $sformatf("v%0d", i));
        end

        // Asynchronous reset while a native request is outstanding.
        idle_cycle();
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'h0000_0300; pwrite = 1'b0; pstrb = 4'h0;
        @(posedge clk); #1;
        penable = 1'b1;
        chk("abort_valid_req", 32'(mem_valid), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_valid_async", 32'(mem_valid), 32'h0);
        chk("abort_pready_async", 32'(pready), 32'h0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        chk("abort_valid_held", 32'(mem_valid), 32'h0);
        rst_n = 1'b1;

        fresh = make_vec(1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'hC0FF_EE00, 1, 0);
        run_xfer(fresh, "post_reset");
        idle_cycle();
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb2mem.md
# apb2mem

APB4 completer-to-native-memory bridge: accepts single APB4 transfers on its completer port and replays each as one valid/ready request on the SoC native memory interface (valid, addr, wdata, wstrb, rdata, ready). It is the reverse of `mem2apb`. It lets an APB-side initiator reach SoC memory space through the same native bus the core uses, for example an externally attached IP behind the IP_MDD port. At most one transfer is in flight; unaligned or timed-out accesses return PSLVERR.

## Interface
Parameters:
- ADDR_OFFSET, 32'h0000_0000, added to the word-aligned PADDR to form `mem_addr_o`
- TIMEOUT_CYCLES, 255, maximum REQ cycles before an error completion; 8-bit counter width (only with `APB2MEM_TIMEOUT_EN`)

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- apb_paddr_i  in  32  APB address
- apb_pprot_i  in  3  protection; ignored
- apb_psel_i  in  1  completer select
- apb_penable_i  in  1  access phase
- apb_pwrite_i  in  1  1 = write
- apb_pwdata_i  in  32  write data
- apb_pstrb_i  in  4  write strobes
- apb_pready_o  out  1  transfer complete
- apb_prdata_o  out  32  read data
- apb_pslverr_o  out  1  error response, valid with pready
- mem_valid_o  out  1  native request valid
- mem_addr_o  out  32  native address, word-aligned
- mem_wdata_o  out  32  native write data
- mem_wstrb_o  out  4  byte strobes; 0 = read
- mem_rdata_i  in  32  native read data
- mem_ready_i  in  1  native request done

## Operation
- States: IDLE, REQ, RESP.
- IDLE, setup phase detected (psel=1, penable=0):
  - Capture addr, write, wdata and strobes.
  - If paddr[1:0]≠0, go to RESP with err=1; no native request.
  - Else if write with pstrb=0, go to RESP with err=0; no native request.
  - Else go to REQ.
- REQ:
  - mem_valid_o=1; addr/wdata/wstrb are held stable from registers.
  - mem_addr_o = {paddr[31:2],2'b00} + ADDR_OFFSET, modulo 2^32.
  - mem_wstrb_o = pstrb for writes, 4'h0 for reads.
  - On mem_ready_i=1, capture rdata (reads only), err=0, go to RESP.
- RESP:
  - apb_pready_o=1 for exactly one cycle, together with prdata and pslverr.
  - prdata=0 on writes and on any error.
  - Then go to IDLE.
- If psel drops mid-transfer (protocol violation), the native request still runs to completion. RESP is still visited for one cycle; no abort.
- Reset values: every output 0, state IDLE, counter 0.

## Timing
- Cycle T0: setup phase. T1: REQ, mem_valid_o=1, pready=0.
- mem_ready_i is sampled at the end of cycle Tk. RESP and pready occur in Tk+1, and mem_valid_o is 0 in Tk+1.
- Minimum read/write: pready in T2, i.e. one APB wait state.
- Error or no-op without a native request: pready in T1, i.e. zero wait states.
- Back-to-back: a setup phase in the cycle after RESP is accepted with no gap.
- mem_valid_o never asserts in IDLE or RESP. mem_ready_i outside REQ is ignored.
- Asynchronous reset during REQ drops mem_valid_o immediately. The native target must tolerate an abandoned request.

## Configuration
- `APB2MEM_TIMEOUT_EN` defined:
  - An 8-bit counter clears on REQ entry and increments each REQ cycle without ready.
  - On reaching TIMEOUT_CYCLES, mem_valid_o drops and the FSM goes to RESP with err=1 and prdata=0.
  - If ready and timeout coincide, ready wins: normal completion.
- Undefined: no counter; REQ waits indefinitely; pslverr is raised only for unaligned addresses.

## Structure
- `apb2mem_pkg`: state enum typedef (IDLE/REQ/RESP) and the timeout counter width constant.
- Optional sub-module `apb2mem_wdt` (load/tick/expire counter), instantiated only under `APB2MEM_TIMEOUT_EN`. Everything else is a single FSM module.

## Test plan
- Aligned read of 0x100, target returns 0xDEAD_BEEF with ready in T1 → mem_addr 0x100, wstrb 0, pready in T2, prdata 0xDEAD_BEEF, pslverr 0.
- Write 0x1234_5678, pstrb 4'b0011, ADDR_OFFSET 0x2000_0000, target ready after 5 cycles → mem_addr 0x2000_0100, wstrb 4'b0011, pready 1 cycle after ready, valid low in that cycle.
- Read of paddr 0x102 → no mem_valid, pready in T1, pslverr 1, prdata 0. Write with pstrb 0 → pready in T1, pslverr 0, no mem_valid.
- With `APB2MEM_TIMEOUT_EN`, TIMEOUT_CYCLES 4, target never ready → valid high for 4 cycles then low, pready with pslverr 1, prdata 0. Repeat with ready arriving on the 4th cycle → pslverr 0.
- Two back-to-back reads, second setup in the RESP-next cycle → both complete, each pready one cycle wide, correct data.
- Assert rst_n_i while in REQ → mem_valid_o and pready low asynchronously. After release, a fresh read completes normally.
